// File: rtl/xc_wb_pipe.sv
// rtl/xc_wb_pipe.sv - two-entry result pipeline feeding the forwarding register file
// S0/S1 buffer execute results, S2 drives the write port; pending loads complete in S1.
module xc_wb_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wen,
  input  logic            in_pend,
  input  logic [4:0]      in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rs3_addr,
  output logic            hz_rs1,
  output logic            hz_rs2,
  output logic            hz_rs3,
  output logic            fwd_0_wen,
  output logic [4:0]      fwd_0_addr,
  output logic [XLEN-1:0] fwd_0_wdata,
  output logic            fwd_1_wen,
  output logic [4:0]      fwd_1_addr,
  output logic [XLEN-1:0] fwd_1_wdata,
  output logic            rd_wen,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata
);

  typedef struct packed {
    logic            valid;
    logic            wen;
    logic            pend;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } stage_t;

  stage_t s0, s1, s2;
  stage_t s0_nxt, s1_nxt, s2_nxt;
  logic   s1_adv, s1_accept, s0_adv, in_xfer;

  assign s1_adv        = s1.valid & (~s1.pend | mem_rsp_valid);
  assign s1_accept     = ~s1.valid | s1_adv;
  assign s0_adv        = s0.valid & s1_accept;
  assign in_ready      = resetn & (~s0.valid | s0_adv);
  assign in_xfer       = in_valid & in_ready & ~flush;
  assign mem_rsp_ready = resetn & s1.valid & s1.pend;

  always_comb begin
    s0_nxt = s0;
    s1_nxt = s1;
    s2_nxt = '0;
    if (s1_adv) begin
      s2_nxt      = s1;
      s2_nxt.pend = 1'b0;
      if (s1.pend) s2_nxt.data = mem_rsp_data;
    end
    if (s0_adv)      s1_nxt = s0;
    else if (s1_adv) s1_nxt = '0;
    // Flush only drops an S0 entry that is not already committed by an advance.
    if (in_xfer) begin
      s0_nxt.valid = 1'b1;
      s0_nxt.wen   = in_wen;
      s0_nxt.pend  = in_pend;
      s0_nxt.addr  = in_addr;
      s0_nxt.data  = in_pend ? {XLEN{1'b0}} : in_wdata;
    end else if (s0_adv | flush) begin
      s0_nxt = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      s0 <= s0_nxt;
      s1 <= s1_nxt;
      s2 <= s2_nxt;
    end
  end

  // The register file matches on address alone, so a non-forwarding stage must present address 0.
  assign fwd_0_wen   = s0.valid & s0.wen & ~s0.pend & (|s0.addr);
  assign fwd_0_addr  = fwd_0_wen ? s0.addr : 5'd0;
  assign fwd_0_wdata = fwd_0_wen ? s0.data : {XLEN{1'b0}};
  assign fwd_1_wen   = s1.valid & s1.wen & ~s1.pend & (|s1.addr);
  assign fwd_1_addr  = fwd_1_wen ? s1.addr : 5'd0;
  assign fwd_1_wdata = fwd_1_wen ? s1.data : {XLEN{1'b0}};

  assign rd_wen   = s2.valid & s2.wen & (|s2.addr);
  assign rd_addr  = s2.addr;
  assign rd_wdata = s2.data;

  // A younger ready S0 writer to the same register shadows an older pending S1 load.
  function automatic logic hazard(input logic [4:0] rs);
    logic s0_match, s1_match;
    s0_match = s0.valid & s0.wen & (s0.addr == rs);
    s1_match = s1.valid & s1.wen & (s1.addr == rs);
    return resetn & (|rs) & ((s0_match & s0.pend) | (s1_match & s1.pend & ~(s0_match & ~s0.pend)));
  endfunction

  assign hz_rs1 = hazard(rs1_addr);
  assign hz_rs2 = hazard(rs2_addr);
  assign hz_rs3 = hazard(rs3_addr);

endmodule

// File: tb/tb_xc_wb_pipe.sv
// tb/tb_xc_wb_pipe.sv - self-checking bench for xc_wb_pipe
// Reference model tracks in-flight results as an age-ordered queue plus one write-back slot.
module tb_xc_wb_pipe;

  logic        clock = 1'b0;
  logic        resetn, flush, in_valid, in_wen, in_pend, mem_rsp_valid;
  logic [4:0]  in_addr, rs1_addr, rs2_addr, rs3_addr;
  logic [31:0] in_wdata, mem_rsp_data;
  logic        in_ready, mem_rsp_ready, hz_rs1, hz_rs2, hz_rs3;
  logic        fwd_0_wen, fwd_1_wen, rd_wen;
  logic [4:0]  fwd_0_addr, fwd_1_addr, rd_addr;
  logic [31:0] fwd_0_wdata, fwd_1_wdata, rd_wdata;

  int n_chk = 0;
  int n_err = 0;

  xc_wb_pipe #(.XLEN(32)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_pend(in_pend),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rs3(hz_rs3),
    .fwd_0_wen(fwd_0_wen), .fwd_0_addr(fwd_0_addr), .fwd_0_wdata(fwd_0_wdata),
    .fwd_1_wen(fwd_1_wen), .fwd_1_addr(fwd_1_addr), .fwd_1_wdata(fwd_1_wdata),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        wen;
    logic        pend;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        front;  // oldest entry that has reached the completion slot
  } ent_t;

  ent_t q[$];
  ent_t wb, tmp, e1, e0;
  bit   wb_v = 0, model_ok = 0, done, rdy, h1, h0;

  function automatic bit head_done();
    return q.size() > 0 && q[0].front && (!q[0].pend || mem_rsp_valid);
  endfunction

  function automatic bit model_ready();
    if (!resetn) return 0;
    if (q.size() == 0 || q[q.size()-1].front) return 1;
    return q.size() == 1 || head_done();
  endfunction

  // Youngest in-flight writer of a register decides whether the read must wait.
  function automatic logic model_hz(input logic [4:0] rs);
    if (!resetn || rs == 5'd0) return 1'b0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].wen && q[i].addr == rs) return q[i].pend;
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      q.delete();
      wb_v     = 0;
      model_ok = 1;
    end else begin
      done = head_done();
      rdy  = model_ready();
      wb_v = done;
      if (done) begin
        wb = q.pop_front();
        if (wb.pend) begin
          wb.data = mem_rsp_data;
          wb.pend = 1'b0;
        end
      end
      if (q.size() > 0 && !q[0].front) begin
        tmp = q[0]; tmp.front = 1'b1; q[0] = tmp;
      end
      if (flush)
        while (q.size() > 0 && !q[q.size()-1].front) void'(q.pop_back());
      if (in_valid && rdy && !flush)
        q.push_back('{wen: in_wen, pend: in_pend, addr: in_addr, data: in_wdata, front: 1'b0});
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      h1 = q.size() > 0 && q[0].front;
      h0 = q.size() > 0 && !q[q.size()-1].front;
      e1 = h1 ? q[0] : '0;
      e0 = h0 ? q[q.size()-1] : '0;
      h1 = h1 && e1.wen && !e1.pend && e1.addr != 5'd0;
      h0 = h0 && e0.wen && !e0.pend && e0.addr != 5'd0;
      chk("in_ready", in_ready, model_ready());
      chk("mem_rsp_ready", mem_rsp_ready, resetn && q.size() > 0 && q[0].front && q[0].pend);
      chk("hz_rs1", hz_rs1, model_hz(rs1_addr));
      chk("hz_rs2", hz_rs2, model_hz(rs2_addr));
      chk("hz_rs3", hz_rs3, model_hz(rs3_addr));
      chk("fwd_1_wen", fwd_1_wen, h1);
      chk("fwd_1_addr", fwd_1_addr, h1 ? e1.addr : 5'd0);
      chk("fwd_1_wdata", fwd_1_wdata, h1 ? e1.data : 32'd0);
      chk("fwd_0_wen", fwd_0_wen, h0);
      chk("fwd_0_addr", fwd_0_addr, h0 ? e0.addr : 5'd0);
      chk("fwd_0_wdata", fwd_0_wdata, h0 ? e0.data : 32'd0);
      chk("rd_wen", rd_wen, wb_v && wb.wen && wb.addr != 5'd0);
      chk("rd_addr", rd_addr, wb_v ? wb.addr : 5'd0);
      chk("rd_wdata", rd_wdata, wb_v ? wb.data : 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic pend, input logic [4:0] addr, input logic [31:0] data);
    in_valid = 1'b1; in_wen = 1'b1; in_pend = pend; in_addr = addr; in_wdata = data;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_wen = 1'b0; in_pend = 1'b0; in_addr = 5'd0; in_wdata = 32'd0;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; flush = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] data);
    mem_rsp_valid = 1'b1; mem_rsp_data = data;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0; rs3_addr = 5'd7;
    tick(); tick();
    resetn = 1'b1;
    #1;
    chk("lit_reset_rd_wen", rd_wen, 1'b0);
    chk("lit_reset_fwd_0_addr", fwd_0_addr, 5'd0);

    // single ALU result through all three stages
    put(1'b0, 5'd5, 32'hDEADBEEF);
    tick(); idle(); #1;
    chk("lit_t1_fwd_0", {fwd_0_wen, fwd_0_addr, fwd_0_wdata[25:0]}, {1'b1, 5'd5, 26'h2ADBEEF});
    tick(); #1;
    chk("lit_t1_fwd_1_data", fwd_1_wdata, 32'hDEADBEEF);
    tick(); #1;
    chk("lit_t1_rd", {rd_wen, rd_addr}, {1'b1, 5'd5});
    chk("lit_t1_rd_data", rd_wdata, 32'hDEADBEEF);
    tick(); #1;
    chk("lit_t1_drained", {rd_wen, rd_addr, fwd_0_wen, fwd_1_wen}, 32'd0);

    // pending load stalls S1, ALU result waits in S0
    put(1'b1, 5'd7, 32'h0);
    tick();
    put(1'b0, 5'd8, 32'h88);
    tick(); idle();
    rs1_addr = 5'd7;
    #1;
    chk("lit_t2_hz_rs1", hz_rs1, 1'b1);
    chk("lit_t2_fwd_1_addr", fwd_1_addr, 5'd0);
    chk("lit_t2_in_ready", in_ready, 1'b0);
    tick(); tick();
    rsp(32'h1234);
    tick(); idle(); #1;
    chk("lit_t2_rd", {rd_wen, rd_addr}, {1'b1, 5'd7});
    chk("lit_t2_rd_data", rd_wdata, 32'h1234);
    chk("lit_t2_fwd_1", {fwd_1_addr, fwd_1_wdata[7:0]}, {5'd8, 8'h88});
    tick(); tick(); tick();

    // back-to-back writes to one register
    put(1'b0, 5'd3, 32'h11);
    tick();
    put(1'b0, 5'd3, 32'h22);
    tick(); idle(); #1;
    chk("lit_t3_fwd_0", fwd_0_wdata, 32'h22);
    chk("lit_t3_fwd_1", fwd_1_wdata, 32'h11);
    tick(); tick(); tick();

    // newer ready writer masks older pending load
    put(1'b1, 5'd3, 32'h0);
    tick();
    put(1'b0, 5'd3, 32'h33);
    tick(); idle();
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    chk("lit_t3_mask_hz", hz_rs1, 1'b0);
    tick();
    rsp(32'h44);
    tick(); idle(); tick(); tick(); tick();

    // address 0 never forwarded, written or hazarded
    rs1_addr = 5'd0;
    put(1'b0, 5'd0, 32'h55);
    tick(); idle(); #1;
    chk("lit_t4_fwd_0", {fwd_0_wen, fwd_0_addr}, 6'd0);
    tick(); #1;
    chk("lit_t4_fwd_1", {fwd_1_wen, fwd_1_addr}, 6'd0);
    tick(); #1;
    chk("lit_t4_rd_wen", rd_wen, 1'b0);
    put(1'b1, 5'd0, 32'h0);
    tick(); idle(); tick(); #1;
    chk("lit_t4_hz0", hz_rs1, 1'b0);
    rsp(32'h66);
    tick(); idle(); tick(); tick();

    // flush with S0 held and S1 stalled
    put(1'b1, 5'd9, 32'h0);
    tick();
    put(1'b0, 5'd10, 32'hA0);
    tick();
    put(1'b0, 5'd11, 32'hB0);
    flush = 1'b1;
    tick(); idle(); #1;
    chk("lit_t5_s0_dropped", fwd_0_wen, 1'b0);
    chk("lit_t5_still_pending", mem_rsp_ready, 1'b1);
    tick();
    rsp(32'h99);
    tick(); idle(); #1;
    chk("lit_t5_rd", {rd_wen, rd_addr}, {1'b1, 5'd9});
    chk("lit_t5_rd_data", rd_wdata, 32'h99);
    tick(); #1;
    chk("lit_t5_no_write", rd_wen, 1'b0);
    tick(); tick();

    // reset while a load is pending
    put(1'b1, 5'd12, 32'h0);
    tick(); idle(); tick();
    rs1_addr = 5'd12;
    resetn = 1'b0;
    put(1'b0, 5'd13, 32'hCC);
    #1;
    chk("lit_t6_rst_in_ready", in_ready, 1'b0);
    chk("lit_t6_rst_hz", hz_rs1, 1'b0);
    tick(); idle();
    resetn = 1'b1;
    rsp(32'hAB);
    #1;
    chk("lit_t6_mem_rsp_ready", mem_rsp_ready, 1'b0);
    tick(); idle(); #1;
    chk("lit_t6_no_write", rd_wen, 1'b0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/xc_wb_pipe.md
Name: xc_wb_pipe

Overview:
- Two-entry result pipeline that sits directly upstream of the forwarding 3-read/1-write register file.
- Accepts execute-stage results through a valid/ready handshake and holds them in S0 and S1.
- Drives the register file's fwd_0 port from S0, its fwd_1 port from S1, and its write port from S2.
- Completes pending load results from a memory response channel and flags read hazards on results not yet available.

Parameters:
- XLEN, 32, data width. Only 32 is supported.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- flush  in  1  kill S0 and any input transfer this cycle
- in_valid  in  1  execute result valid
- in_ready  out  1  pipeline can accept a result
- in_wen  in  1  result writes a GPR
- in_pend  in  1  result data comes from a later memory response
- in_addr  in  5  destination register
- in_wdata  in  32  result data (ignored if in_pend)
- mem_rsp_valid  in  1  load data valid
- mem_rsp_ready  out  1  S1 is waiting for load data
- mem_rsp_data  in  32  load data
- rs1_addr, rs2_addr, rs3_addr  in  5 each  consumer read addresses
- hz_rs1, hz_rs2, hz_rs3  out  1 each  read hits an in-flight pending result
- fwd_0_wen, fwd_1_wen  out  1 each  forward stage valid
- fwd_0_addr, fwd_1_addr  out  5 each  forward address
- fwd_0_wdata, fwd_1_wdata  out  32 each  forward data
- rd_wen  out  1  register file write enable
- rd_addr  out  5  register file write address
- rd_wdata  out  32  register file write data

Behaviour:
- Each stage Sk holds {valid, wen, pend, addr, data}.
- Reset (resetn low at a clock edge): all valid/wen/pend/addr/data cleared.
  - While resetn is low: in_ready=0, mem_rsp_ready=0, all hz=0.
  - After reset: all fwd/rd outputs are 0.
- S2 drains unconditionally, one cycle per entry. rd_wen = s2_valid & s2_wen & |s2_addr. rd_addr and rd_wdata come from S2.
- S1 advance: s1_adv = s1_valid & (!s1_pend | mem_rsp_valid).
  - On a pending advance, S2.data <= mem_rsp_data and S2.pend = 0.
  - mem_rsp_ready = s1_valid & s1_pend. A response arriving while mem_rsp_ready=0 is a protocol error and is ignored.
- S1 accepts when !s1_valid | s1_adv. S0 advances when s0_valid & s1 accepts. in_ready = !s0_valid | s0_adv, combinational.
- Input transfer when in_valid & in_ready & !flush; the entry loads into S0. Invalid stages are bubbles; a bubble enters S2 when S1 does not advance.
- Forwarding outputs, for N in {0,1} fed by S(N):
  - fwd_N_wen = valid & wen & !pend.
  - fwd_N_addr = fwd_N_wen ? addr : 0.
  - fwd_N_wdata = fwd_N_wen ? data : 0.
  - Zeroing the address is mandatory: the register file matches addresses without qualifying by wen.
- Hazard: hz_rsX = |rsX_addr & ((S0 valid&wen&pend & S0.addr==rsX_addr) | (S1 valid&wen&pend & S1.addr==rsX_addr)).
  - A match on a newer non-pending S0 entry masks an older pending S1 entry with the same address, so no hazard is raised.
- Flush: S0.valid cleared at the next edge and any same-cycle input is dropped.
  - S1 and S2 are unaffected; a pending load already in S1 still waits for its response.
  - Flush and S0 advance in the same cycle: the S0 entry still moves to S1, because it is already committed by the advance.
- Address 0 is never forwarded, never written and never hazarded.
- Latency: a non-pending result is visible on fwd_0 the cycle after acceptance and on fwd_1 the cycle after that (if S1 was free). It is written to the register file one cycle later.
- Stall behaviour: when S1 is stalled by a pending load, S0 holds and in_ready falls only once S0 is occupied. At most 2 results are buffered.

Test Plan:
- Reset, then in_valid=1 with addr=5, wdata=0xDEADBEEF, wen=1, pend=0 for one cycle.
  - Required: fwd_0 = (1,5,0xDEADBEEF) in cycle 1, fwd_1 the same in cycle 2, rd_wen=1/5/0xDEADBEEF in cycle 3, all zero in cycle 4.
- Pending load to addr 7 accepted, then ALU result addr=8 in the next cycle, with mem_rsp_valid held low for 3 cycles.
  - Required: S1 stalls; hz_rs1=1 while rs1_addr=7; fwd_1_addr=0; in_ready=0 once S0 holds addr 8.
  - Then mem_rsp_data=0x1234 with valid: the next cycle rd writes 7/0x1234, and addr 8 moves to fwd_1.
- Back-to-back writes to addr 3 (values 0x11, then 0x22).
  - Required: the cycle after the second is accepted, fwd_0=0x22 and fwd_1=0x11.
  - Pending S1 to addr 3 with a non-pending S0 to addr 3 must give hz_rs1=0 for rs1_addr=3.
- in_addr=0 with wen=1.
  - Required: fwd_N_wen, fwd_N_addr, rd_wen all stay 0; hz=0 for rs_addr=0.
- flush asserted together with in_valid while S0 is occupied and S1 is stalled.
  - Required: S0 entry and input are both dropped, no later write occurs, and the S1 load still completes on its response.
- resetn low for one cycle while S1 is pending.
  - Required: all state is cleared; mem_rsp_ready=0; a response arriving the next cycle produces no register write.
